// File: rtl/damage_scheduler_pkg.sv
// Shared definitions for the damage scheduler slice (package damage_pkg).
//   - Scan geometry: NUM_ATTACKERS attackers polled per target and NUM_TARGETS
//     targets (0..15 are units, TOWER_IDX is the tower).
//   - Default widths: DMG_WIDTH (per-attacker damage) and ACC_WIDTH (accumulator).
//   - FSM encoding state_t = {IDLE, SCAN, APPLY, DONE}.
//   - target_hit(): the attacker/target match rule used during SCAN.
package damage_pkg;

  localparam int NUM_ATTACKERS = 16;
  localparam int NUM_TARGETS   = 17;
  localparam int DMG_WIDTH     = 8;
  localparam int ACC_WIDTH     = 12;
  localparam int ATK_W         = 4;
  localparam int TGT_W         = 5;

  // Last target of a pass; the tower always sits at the top index.
  localparam logic [TGT_W-1:0]     TOWER_IDX = TGT_W'(NUM_TARGETS - 1);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX   = 12'hFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    APPLY = 2'd2,
    DONE  = 2'd3
  } state_t;

  // An attacker contributes only when alive and aimed at the target being
  // summed. Targets are never above TOWER_IDX, so out-of-range attacker target
  // indices simply never match and their damage is dropped.
  function automatic logic target_hit(input logic             valid,
                                      input logic [TGT_W-1:0] target,
                                      input logic [TGT_W-1:0] current);
    return valid && (target == current);
  endfunction

endpackage

// File: rtl/damage_scheduler_if.sv
// Bus between the damage scheduler and its environment.
//   start           environment -> scheduler  1-cycle pass request
//   attackerSel     scheduler -> environment  attacker being polled
//   attackerValid   environment -> scheduler  combinational reply: attacker alive and attacking
//   attackerTarget  environment -> scheduler  combinational reply: its target index
//   attackerDamage  environment -> scheduler  combinational reply: its damage
//   damageSelect    scheduler -> decoder      target index
//   totalDamage     scheduler -> decoder      summed damage, 0 outside APPLY
//   applyValid      scheduler -> decoder      qualifies damageSelect/totalDamage
//   busy, done      scheduler -> environment  pass status
// Handshake: applyValid is a valid-only strobe with no ready; the decoder must
// accept {damageSelect, totalDamage} in every cycle applyValid is high. The
// attacker poll is likewise ready-free: the reply must be valid in the same
// cycle attackerSel is presented.
// Modports: master = scheduler side, slave = environment/decoder side.
interface damage_scheduler_if #(
  parameter int DMG_W = damage_pkg::DMG_WIDTH,
  parameter int ACC_W = damage_pkg::ACC_WIDTH
);

  logic                           start;
  logic [damage_pkg::ATK_W-1:0]   attackerSel;
  logic                           attackerValid;
  logic [damage_pkg::TGT_W-1:0]   attackerTarget;
  logic [DMG_W-1:0]               attackerDamage;
  logic [damage_pkg::TGT_W-1:0]   damageSelect;
  logic [ACC_W-1:0]               totalDamage;
  logic                           applyValid;
  logic                           busy;
  logic                           done;

  modport master (
    input  start, attackerValid, attackerTarget, attackerDamage,
    output attackerSel, damageSelect, totalDamage, applyValid, busy, done
  );

  modport slave (
    output start, attackerValid, attackerTarget, attackerDamage,
    input  attackerSel, damageSelect, totalDamage, applyValid, busy, done
  );

endinterface

// File: rtl/damage_sat_acc.sv
// Saturating damage accumulator.
//   clk, rst   clock and synchronous active-high reset
//   clr        zero the accumulator (wins over add_en)
//   add_en     add add_val this cycle
//   add_val    DMG_W-bit damage to add
//   acc        ACC_W-bit running total, sticks at its maximum and never wraps
// DMG_W must not exceed ACC_W.
module damage_sat_acc
  import damage_pkg::*;
#(
  parameter int DMG_W = DMG_WIDTH,
  parameter int ACC_W = ACC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             add_en,
  input  logic [DMG_W-1:0] add_val,
  output logic [ACC_W-1:0] acc
);

  // The default build saturates at the shared ACC_MAX; narrower builds
  // saturate at their own all-ones value.
  localparam logic [ACC_W-1:0] SAT_MAX =
    (ACC_W == ACC_WIDTH) ? ACC_W'(ACC_MAX) : {ACC_W{1'b1}};

  // One extra bit catches the carry so overflow can be replaced by SAT_MAX.
  logic [ACC_W:0] sum;

  assign sum = {1'b0, acc} + (ACC_W + 1)'(add_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= sum[ACC_W] ? SAT_MAX : sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/damage_scheduler.sv
// Combat-resolution sequencer for one side (units or enemies).
// For each target 0..TOWER_IDX it polls all attackers, one per cycle, sums the
// damage aimed at that target, then presents {damageSelect, totalDamage} to the
// damage decoder for one APPLY cycle. A pass is 17 x (16 + 1) = 289 cycles from
// start to the last APPLY, followed by a one-cycle done pulse.
// Ports:
//   Clk, Reset  clock and synchronous active-high reset (all outputs go to 0)
//   bus         damage_scheduler_if.master (poll, decoder and status signals)
//   dbg_state   current FSM state
// Build option:
//   SKIP_ZERO_EN  when defined, APPLY cycles with a zero total keep applyValid
//                 low; the slot is still spent so pass timing is unchanged.
module damage_scheduler
  import damage_pkg::*;
#(
  parameter int DMG_W = DMG_WIDTH,
  parameter int ACC_W = ACC_WIDTH
) (
  input  logic                Clk,
  input  logic                Reset,
  damage_scheduler_if.master  bus,
  output state_t              dbg_state
);

  localparam logic [ATK_W-1:0] LAST_ATK = ATK_W'(NUM_ATTACKERS - 1);

  state_t           state_q;
  state_t           state_d;
  logic [ATK_W-1:0] atk_q;
  logic [TGT_W-1:0] tgt_q;
  logic [TGT_W-1:0] sel_q;
  logic [ACC_W-1:0] acc;
  logic             acc_clr;
  logic             acc_add;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state. start is honoured only in IDLE, so a request during a
  // pass or in the DONE cycle is dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start)            state_d = SCAN;
      SCAN:    if (atk_q == LAST_ATK)    state_d = APPLY;
      APPLY:   state_d = (tgt_q == TOWER_IDX) ? DONE : SCAN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Attacker / target counters and the held decoder select
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      atk_q <= '0;
      tgt_q <= '0;
      sel_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            atk_q <= '0;
            tgt_q <= '0;
          end
        end
        SCAN: begin
          atk_q <= (atk_q == LAST_ATK) ? '0 : atk_q + 1'b1;
        end
        APPLY: begin
          // damageSelect keeps showing the last applied target afterwards.
          sel_q <= tgt_q;
          atk_q <= '0;
          if (tgt_q != TOWER_IDX) begin
            tgt_q <= tgt_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator: cleared when a pass starts and after every APPLY, so each
  // target starts its scan from zero.
  // ---------------------------------------------------------------------------
  assign acc_clr = ((state_q == IDLE) && bus.start) || (state_q == APPLY);
  assign acc_add = (state_q == SCAN) &&
                   target_hit(bus.attackerValid, bus.attackerTarget, tgt_q);

  damage_sat_acc #(
    .DMG_W (DMG_W),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk     (Clk),
    .rst     (Reset),
    .clr     (acc_clr),
    .add_en  (acc_add),
    .add_val (bus.attackerDamage),
    .acc     (acc)
  );

  // ---------------------------------------------------------------------------
  // FSM outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.attackerSel  = atk_q;
    bus.damageSelect = sel_q;
    bus.totalDamage  = '0;
    bus.applyValid   = 1'b0;
    bus.busy         = 1'b0;
    bus.done         = 1'b0;
    case (state_q)
      SCAN: begin
        bus.busy = 1'b1;
      end
      APPLY: begin
        bus.busy         = 1'b1;
        bus.damageSelect = tgt_q;
        bus.totalDamage  = acc;
`ifdef SKIP_ZERO_EN
        bus.applyValid   = (acc != '0);
`else
        bus.applyValid   = 1'b1;
`endif
      end
      DONE: begin
        bus.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_damage_scheduler.sv
// Bench for damage_scheduler: a 12-bit and an 8-bit accumulator build run in
// lockstep from one attacker table. Expected per-target totals come from a
// direct sum over the table, saturated at each build's maximum.
module tb_damage_scheduler;
  import damage_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  logic start;

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  damage_scheduler_if #(.DMG_W(8), .ACC_W(12)) bus_w ();
  damage_scheduler_if #(.DMG_W(8), .ACC_W(8))  bus_n ();

  state_t st_w;
  state_t st_n;

  damage_scheduler #(.DMG_W(8), .ACC_W(12)) dut_w (
    .Clk       (clk),
    .Reset     (rst),
    .bus       (bus_w),
    .dbg_state (st_w)
  );

  damage_scheduler #(.DMG_W(8), .ACC_W(8)) dut_n (
    .Clk       (clk),
    .Reset     (rst),
    .bus       (bus_n),
    .dbg_state (st_n)
  );

  // Attacker table answered combinationally from attackerSel.
  logic       tb_valid [16];
  logic [4:0] tb_tgt   [16];
  logic [7:0] tb_dmg   [16];

  assign bus_w.start          = start;
  assign bus_w.attackerValid  = tb_valid[bus_w.attackerSel];
  assign bus_w.attackerTarget = tb_tgt[bus_w.attackerSel];
  assign bus_w.attackerDamage = tb_dmg[bus_w.attackerSel];

  assign bus_n.start          = start;
  assign bus_n.attackerValid  = tb_valid[bus_n.attackerSel];
  assign bus_n.attackerTarget = tb_tgt[bus_n.attackerSel];
  assign bus_n.attackerDamage = tb_dmg[bus_n.attackerSel];

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int vectors     = 0;
  int miscompares = 0;
  logic [11:0] exp_q   [$];
  logic [7:0]  exp_n_q [$];
  int exp_pulses;
  int last_sel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each target's total is the plain sum of damage from live
  // attackers aimed at it, clipped to the accumulator maximum.
  task automatic build_expect();
    int s;
    exp_q.delete();
    exp_n_q.delete();
    exp_pulses = 0;
    for (int t = 0; t < 17; t++) begin
      s = 0;
      for (int a = 0; a < 16; a++) begin
        if (tb_valid[a] && (int'(tb_tgt[a]) == t)) s += int'(tb_dmg[a]);
      end
      exp_q.push_back(12'((s > 4095) ? 4095 : s));
      exp_n_q.push_back(8'((s > 255) ? 255 : s));
`ifdef SKIP_ZERO_EN
      if (s != 0) exp_pulses++;
`else
      exp_pulses++;
`endif
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic clear_table();
    for (int a = 0; a < 16; a++) begin
      tb_valid[a] = 1'b0;
      tb_tgt[a]   = 5'd0;
      tb_dmg[a]   = 8'd0;
    end
  endtask

  task automatic random_table(input bit narrow);
    for (int a = 0; a < 16; a++) begin
      tb_valid[a] = ($urandom_range(0, 3) != 0);
      if (narrow)
        tb_tgt[a] = 5'($urandom_range(0, 3));
      else if ($urandom_range(0, 4) == 0)
        tb_tgt[a] = 5'($urandom_range(17, 31));
      else
        tb_tgt[a] = 5'($urandom_range(0, 16));
      tb_dmg[a] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_state_w"}, 32'(st_w), 32'(IDLE));
    check({tag, "_state_n"}, 32'(st_n), 32'(IDLE));
    check({tag, "_sel"},     32'(bus_w.attackerSel), 0);
    check({tag, "_dsel"},    32'(bus_w.damageSelect), 0);
    check({tag, "_total"},   32'(bus_w.totalDamage), 0);
    check({tag, "_apply"},   32'(bus_w.applyValid), 0);
    check({tag, "_busy"},    32'(bus_w.busy), 0);
    check({tag, "_done_w"},  32'(bus_w.done), 0);
    check({tag, "_done_n"},  32'(bus_n.done), 0);
    check({tag, "_dsel_n"},  32'(bus_n.damageSelect), 0);
  endtask

  // One full pass. stray_at (1..289) raises start during that busy cycle; a
  // start is also raised in the DONE cycle. Both must be ignored.
  task automatic run_pass(input string tag, input int stray_at);
    int t, p, pulses;
    logic [11:0] ew;
    logic [7:0]  en;
    logic        exp_av;
    build_expect();
    pulses = 0;
    @(negedge clk);
    check({tag, "_pre_busy"}, 32'(bus_w.busy), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 290; c++) begin
      t = (c - 1) / 17;
      p = (c - 1) % 17;
      if (c == 290) begin
        check({tag, "_done"},      32'(bus_w.done), 1);
        check({tag, "_done_n"},    32'(bus_n.done), 1);
        check({tag, "_done_busy"}, 32'(bus_w.busy), 0);
        check({tag, "_done_st"},   32'(st_w), 32'(DONE));
      end else if (p < 16) begin
        check({tag, "_atk_sel"},   32'(bus_w.attackerSel), p);
        check({tag, "_atk_sel_n"}, 32'(bus_n.attackerSel), p);
        check({tag, "_busy"},      32'(bus_w.busy), 1);
        check({tag, "_scan_tot"},  32'(bus_w.totalDamage), 0);
        check({tag, "_scan_av"},   32'(bus_w.applyValid), 0);
        check({tag, "_dsel_hold"}, 32'(bus_w.damageSelect), last_sel);
        check({tag, "_no_done"},   32'(bus_w.done), 0);
      end else begin
        ew = exp_q.pop_front();
        en = exp_n_q.pop_front();
`ifdef SKIP_ZERO_EN
        exp_av = (ew != 12'd0);
`else
        exp_av = 1'b1;
`endif
        check({tag, "_dsel"},    32'(bus_w.damageSelect), t);
        check({tag, "_dsel_n"},  32'(bus_n.damageSelect), t);
        check({tag, "_total_w"}, 32'(bus_w.totalDamage), 32'(ew));
        check({tag, "_total_n"}, 32'(bus_n.totalDamage), 32'(en));
        check({tag, "_av_w"},    32'(bus_w.applyValid), 32'(exp_av));
        check({tag, "_av_n"},    32'(bus_n.applyValid), 32'(exp_av));
        check({tag, "_ap_busy"}, 32'(bus_w.busy), 1);
        if (bus_w.applyValid) pulses++;
        last_sel = t;
      end
      start = (c == stray_at) || (c == 290);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_end_st"},   32'(st_w), 32'(IDLE));
    check({tag, "_end_busy"}, 32'(bus_w.busy), 0);
    check({tag, "_end_done"}, 32'(bus_w.done), 0);
    check({tag, "_pulses"},   32'(pulses), 32'(exp_pulses));
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    last_sel = 0;
    clear_table();
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;

    // Two hits on target 4.
    clear_table();
    tb_valid[2] = 1'b1; tb_tgt[2] = 5'd4; tb_dmg[2] = 8'd10;
    tb_valid[5] = 1'b1; tb_tgt[5] = 5'd4; tb_dmg[5] = 8'd20;
    run_pass("t4", 0);

    // Whole side on the tower: 16 x 255.
    for (int a = 0; a < 16; a++) begin
      tb_valid[a] = 1'b1; tb_tgt[a] = 5'd16; tb_dmg[a] = 8'd255;
    end
    run_pass("tower", 0);

    // Two 255 hits: the 8-bit build must clip at 255.
    clear_table();
    tb_valid[3] = 1'b1; tb_tgt[3] = 5'd7; tb_dmg[3] = 8'd255;
    tb_valid[9] = 1'b1; tb_tgt[9] = 5'd7; tb_dmg[9] = 8'd255;
    run_pass("sat", 0);

    // Dead attacker aimed at target 0, plus a start while busy.
    clear_table();
    tb_valid[0] = 1'b0; tb_tgt[0] = 5'd0; tb_dmg[0] = 8'd99;
    tb_valid[8] = 1'b1; tb_tgt[8] = 5'd20; tb_dmg[8] = 8'd50;
    run_pass("inval", 100);

    // Reset in SCAN at tgt=3, atk=7: pass abandoned, no done pulse.
    random_table(1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3 * 17 + 7) @(negedge clk);
    check("midrst_atk", 32'(bus_w.attackerSel), 7);
    check("midrst_dsel", 32'(bus_w.damageSelect), 2);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("midrst");
    rst = 1'b0;
    last_sel = 0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_done", 32'(bus_w.done), 0);
      check("midrst_idle", 32'(bus_w.busy), 0);
    end

    // Randomized passes.
    for (int i = 0; i < 6; i++) begin
      random_table(i[0]);
      run_pass($sformatf("rnd%0d", i), $urandom_range(0, 289));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
